// File: rtl/oneapi_gasket_pkg.sv
// Shared types for the oneAPI AXI4-S video gasket front end.
package oneapi_gasket_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        RUN      = 2'd2
    } seq_state_t;

    localparam int unsigned SOF_BIT = 0;

endpackage

// File: rtl/oneapi_line_frame_counter.sv
// Beat/line position tracking against latched geometry; flags are qualified by the caller's beat strobe.
module oneapi_line_frame_counter #(
    parameter int unsigned BEAT_CNT_W = 16,
    parameter int unsigned LINE_CNT_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_beat,
    input  logic                  i_start,
    input  logic                  i_tlast,
    input  logic [BEAT_CNT_W-1:0] i_cfg_line_beats,
    input  logic [LINE_CNT_W-1:0] i_cfg_frame_lines,
    output logic                  o_short,
    output logic                  o_long,
    output logic                  o_frame_end,
    output logic                  o_mid_frame
);

    localparam logic [BEAT_CNT_W-1:0] BEAT_ONE = BEAT_CNT_W'(1);
    localparam logic [LINE_CNT_W-1:0] LINE_ONE = LINE_CNT_W'(1);

    logic [BEAT_CNT_W-1:0] r_beat_cnt;
    logic [LINE_CNT_W-1:0] r_line_cnt;
    logic [BEAT_CNT_W-1:0] r_lat_line_beats;
    logic [LINE_CNT_W-1:0] r_lat_frame_lines;

    logic [BEAT_CNT_W-1:0] w_line_beats;
    logic [LINE_CNT_W-1:0] w_frame_lines;
    logic [BEAT_CNT_W-1:0] w_beat_inc;
    logic [LINE_CNT_W-1:0] w_line_cur;
    logic [LINE_CNT_W-1:0] w_line_inc;

    // A start beat is evaluated as beat 0 of line 0 against the incoming geometry.
    assign w_line_beats  = i_start ? i_cfg_line_beats  : r_lat_line_beats;
    assign w_frame_lines = i_start ? i_cfg_frame_lines : r_lat_frame_lines;
    assign w_beat_inc    = (i_start ? '0 : r_beat_cnt) + BEAT_ONE;
    assign w_line_cur    = i_start ? '0 : r_line_cnt;
    assign w_line_inc    = w_line_cur + LINE_ONE;

    assign o_short     = i_tlast && (w_beat_inc < w_line_beats);
    assign o_long      = !i_tlast && (w_beat_inc == w_line_beats);
    assign o_frame_end = i_tlast && (w_line_inc == w_frame_lines);
    assign o_mid_frame = (r_beat_cnt != '0) || (r_line_cnt != '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_beat_cnt        <= '0;
            r_line_cnt        <= '0;
            r_lat_line_beats  <= '0;
            r_lat_frame_lines <= '0;
        end else if (i_beat) begin
            if (i_start) begin
                r_lat_line_beats  <= i_cfg_line_beats;
                r_lat_frame_lines <= i_cfg_frame_lines;
            end
            r_beat_cnt <= (i_tlast || o_long) ? '0 : w_beat_inc;
            if (i_tlast) begin
                r_line_cnt <= o_frame_end ? '0 : w_line_inc;
            end else begin
                r_line_cnt <= w_line_cur;
            end
        end
    end

endmodule

// File: rtl/oneapi_axs_frame_sequencer.sv
// Frame-boundary gate in front of the pixel gasket: aligns to SOF, checks geometry, counts good frames.
module oneapi_axs_frame_sequencer
    import oneapi_gasket_pkg::*;
#(
    parameter int unsigned BITS_AXI    = 24,
    parameter int unsigned TUSER_BITS  = 3,
    parameter int unsigned BEAT_CNT_W  = 16,
    parameter int unsigned LINE_CNT_W  = 16,
    parameter int unsigned FRAME_CNT_W = 32
) (
    input  logic                   csi_clk,
    input  logic                   rsi_reset,
    input  logic                   cfg_enable,
    input  logic [BEAT_CNT_W-1:0]  cfg_line_beats,
    input  logic [LINE_CNT_W-1:0]  cfg_frame_lines,
    input  logic                   err_clear,
    input  logic                   axs_tvalid,
    output logic                   axs_tready,
    input  logic [BITS_AXI-1:0]    axs_tdata,
    input  logic                   axs_tlast,
    input  logic [TUSER_BITS-1:0]  axs_tuser,
    output logic                   axm_tvalid,
    input  logic                   axm_tready,
    output logic [BITS_AXI-1:0]    axm_tdata,
    output logic                   axm_tlast,
    output logic [TUSER_BITS-1:0]  axm_tuser,
    output logic                   sts_busy,
    output logic [FRAME_CNT_W-1:0] sts_frame_count,
    output logic                   sts_err_short,
    output logic                   sts_err_long,
    output logic                   sts_err_early_sof
);

    seq_state_t             r_state;
    logic                   r_busy;
    logic                   r_frame_err;
    logic [FRAME_CNT_W-1:0] r_frame_count;
    logic                   r_err_short;
    logic                   r_err_long;
    logic                   r_err_early_sof;

    logic w_sof, w_beat, w_pass, w_start, w_cfg_ok;
    logic w_short, w_long, w_frame_end, w_mid_frame;
    logic w_set_short, w_set_long, w_set_early, w_frame_done, w_frame_bad;

    assign axm_tdata = axs_tdata;
    assign axm_tlast = axs_tlast;
    assign axm_tuser = axs_tuser;

    assign w_sof    = axs_tuser[SOF_BIT];
    assign w_cfg_ok = (cfg_line_beats != '0) && (cfg_frame_lines != '0);

    always_comb begin
        axs_tready = 1'b1;
        axm_tvalid = 1'b0;
        case (r_state)
            WAIT_SOF: if (w_sof) begin
                axs_tready = axm_tready;
                axm_tvalid = axs_tvalid;
            end
            RUN: begin
                axs_tready = axm_tready;
                axm_tvalid = axs_tvalid;
            end
            default: ;
        endcase
    end

    assign w_beat  = axs_tvalid && axs_tready;
    assign w_pass  = w_beat && ((r_state == RUN) || ((r_state == WAIT_SOF) && w_sof));
    assign w_start = w_pass && w_sof;

    oneapi_line_frame_counter #(
        .BEAT_CNT_W (BEAT_CNT_W),
        .LINE_CNT_W (LINE_CNT_W)
    ) u_counter (
        .i_clk             (csi_clk),
        .i_reset           (rsi_reset),
        .i_beat            (w_pass),
        .i_start           (w_start),
        .i_tlast           (axs_tlast),
        .i_cfg_line_beats  (cfg_line_beats),
        .i_cfg_frame_lines (cfg_frame_lines),
        .o_short           (w_short),
        .o_long            (w_long),
        .o_frame_end       (w_frame_end),
        .o_mid_frame       (w_mid_frame)
    );

    assign w_set_short  = w_pass && w_short;
    assign w_set_long   = w_pass && w_long;
    assign w_set_early  = w_start && (r_state == RUN) && w_mid_frame;
    assign w_frame_done = w_pass && w_frame_end;
    // An early SOF abandons the old frame; its errors do not follow into the new one.
    assign w_frame_bad  = (r_frame_err && !w_start) || w_set_short || w_set_long;

    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            r_state         <= IDLE;
            r_busy          <= 1'b0;
            r_frame_err     <= 1'b0;
            r_frame_count   <= '0;
            r_err_short     <= 1'b0;
            r_err_long      <= 1'b0;
            r_err_early_sof <= 1'b0;
        end else begin
            r_err_short     <= (r_err_short     && !err_clear) || w_set_short;
            r_err_long      <= (r_err_long      && !err_clear) || w_set_long;
            r_err_early_sof <= (r_err_early_sof && !err_clear) || w_set_early;

            if (w_pass) begin
                r_frame_err <= w_frame_done ? 1'b0 : w_frame_bad;
            end
            if (w_frame_done && !w_frame_bad) begin
                r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
            end

            case (r_state)
                IDLE: begin
                    r_busy <= 1'b0;
                    if (cfg_enable && w_cfg_ok) begin
                        r_state <= WAIT_SOF;
                    end
                end
                WAIT_SOF: begin
                    if (w_start) begin
                        if (w_frame_done) begin
                            r_state <= cfg_enable ? WAIT_SOF : IDLE;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end
                    end else if (!cfg_enable) begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    if (w_frame_done) begin
                        r_state <= cfg_enable ? WAIT_SOF : IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sts_busy          = r_busy;
    assign sts_frame_count   = r_frame_count;
    assign sts_err_short     = r_err_short;
    assign sts_err_long      = r_err_long;
    assign sts_err_early_sof = r_err_early_sof;

endmodule

// File: tb/tb_oneapi_axs_frame_sequencer.sv
// Directed bench for the frame sequencer: vector table for gating, hand sequences for frame corner cases.
module tb_oneapi_axs_frame_sequencer;

    logic        csi_clk = 1'b0;
    logic        rsi_reset;
    logic        cfg_enable;
    logic [15:0] cfg_line_beats;
    logic [15:0] cfg_frame_lines;
    logic        err_clear;
    logic        axs_tvalid;
    logic        axs_tready;
    logic [23:0] axs_tdata;
    logic        axs_tlast;
    logic [2:0]  axs_tuser;
    logic        axm_tvalid;
    logic        axm_tready;
    logic [23:0] axm_tdata;
    logic        axm_tlast;
    logic [2:0]  axm_tuser;
    logic        sts_busy;
    logic [31:0] sts_frame_count;
    logic        sts_err_short;
    logic        sts_err_long;
    logic        sts_err_early_sof;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pass  = 0;
    int exp_cnt = 0;

    always #5 csi_clk = ~csi_clk;

    oneapi_axs_frame_sequencer #(
        .BITS_AXI    (24),
        .TUSER_BITS  (3),
        .BEAT_CNT_W  (16),
        .LINE_CNT_W  (16),
        .FRAME_CNT_W (32)
    ) dut (
        .csi_clk           (csi_clk),
        .rsi_reset         (rsi_reset),
        .cfg_enable        (cfg_enable),
        .cfg_line_beats    (cfg_line_beats),
        .cfg_frame_lines   (cfg_frame_lines),
        .err_clear         (err_clear),
        .axs_tvalid        (axs_tvalid),
        .axs_tready        (axs_tready),
        .axs_tdata         (axs_tdata),
        .axs_tlast         (axs_tlast),
        .axs_tuser         (axs_tuser),
        .axm_tvalid        (axm_tvalid),
        .axm_tready        (axm_tready),
        .axm_tdata         (axm_tdata),
        .axm_tlast         (axm_tlast),
        .axm_tuser         (axm_tuser),
        .sts_busy          (sts_busy),
        .sts_frame_count   (sts_frame_count),
        .sts_err_short     (sts_err_short),
        .sts_err_long      (sts_err_long),
        .sts_err_early_sof (sts_err_early_sof)
    );

    // Bit order: en, tvalid, tlast, sof, m_tready, exp_s_tready, exp_m_tvalid
    typedef struct packed {
        logic en;
        logic tv;
        logic tl;
        logic sof;
        logic mr;
        logic etr;
        logic emv;
    } vec_t;

    vec_t vecs [22];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic tv, input logic tl, input logic sof, input logic mr,
                         input logic etr, input logic emv, input string nm);
        @(negedge csi_clk);
        axs_tvalid = tv;
        axs_tlast  = tl;
        axs_tuser  = {2'($urandom_range(0, 3)), sof};
        axs_tdata  = 24'($urandom);
        axm_tready = mr;
        #1;
        check({nm, "_s_tready"}, {31'd0, axs_tready}, {31'd0, etr});
        check({nm, "_m_tvalid"}, {31'd0, axm_tvalid}, {31'd0, emv});
        check({nm, "_thru"}, {4'd0, axm_tdata, axm_tlast, axm_tuser},
                             {4'd0, axs_tdata, axs_tlast, axs_tuser});
        if (axm_tvalid && axm_tready) n_pass++;
        @(posedge csi_clk);
        #1;
        axs_tvalid = 1'b0;
    endtask

    task automatic send_line(input int n, input logic sof, input logic tl_end, input string nm);
        for (int b = 0; b < n; b++) begin
            drive(1'b1, tl_end && (b == n - 1), sof && (b == 0), 1'b1, 1'b1, 1'b1, nm);
        end
    endtask

    task automatic chk_sts(input string nm, input logic busy, input logic es, input logic el,
                           input logic ee, input int cnt);
        check({nm, "_busy"},  {31'd0, sts_busy},          {31'd0, busy});
        check({nm, "_short"}, {31'd0, sts_err_short},     {31'd0, es});
        check({nm, "_long"},  {31'd0, sts_err_long},      {31'd0, el});
        check({nm, "_early"}, {31'd0, sts_err_early_sof}, {31'd0, ee});
        check({nm, "_count"}, sts_frame_count, cnt);
    endtask

    task automatic pulse_clear();
        @(negedge csi_clk);
        err_clear = 1'b1;
        @(posedge csi_clk);
        #1;
        err_clear = 1'b0;
    endtask

    initial begin
        int got;
        int cyc;
        logic mr;

        rsi_reset       = 1'b1;
        cfg_enable      = 1'b0;
        cfg_line_beats  = 16'd4;
        cfg_frame_lines = 16'd3;
        err_clear       = 1'b0;
        axs_tvalid      = 1'b0;
        axs_tlast       = 1'b0;
        axs_tuser       = '0;
        axs_tdata       = '0;
        axm_tready      = 1'b1;

        vecs[0]  = 7'b0101110;
        vecs[1]  = 7'b1000110;
        vecs[2]  = 7'b1100110;
        vecs[3]  = 7'b1100110;
        vecs[4]  = 7'b1110110;
        vecs[5]  = 7'b1101001;
        vecs[6]  = 7'b1101111;
        vecs[7]  = 7'b1100111;
        vecs[8]  = 7'b1100001;
        vecs[9]  = 7'b1100111;
        vecs[10] = 7'b1110111;
        vecs[11] = 7'b1000110;
        vecs[12] = 7'b1100111;
        vecs[13] = 7'b1100111;
        vecs[14] = 7'b1100111;
        vecs[15] = 7'b1110111;
        vecs[16] = 7'b1000000;
        vecs[17] = 7'b1100111;
        vecs[18] = 7'b1100111;
        vecs[19] = 7'b1100111;
        vecs[20] = 7'b1110111;
        vecs[21] = 7'b1100110;

        repeat (3) @(posedge csi_clk);
        #1;
        axs_tvalid = 1'b1;
        axs_tuser  = 3'b001;
        #1;
        chk_sts("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("reset_s_tready", {31'd0, axs_tready}, 32'd1);
        check("reset_m_tvalid", {31'd0, axm_tvalid}, 32'd0);
        @(negedge csi_clk);
        rsi_reset  = 1'b0;
        axs_tvalid = 1'b0;

        // Enable, junk before SOF, first 4x3 frame with stalls
        for (int i = 0; i < 22; i++) begin
            cfg_enable = vecs[i].en;
            drive(vecs[i].tv, vecs[i].tl, vecs[i].sof, vecs[i].mr, vecs[i].etr, vecs[i].emv,
                  $sformatf("vec%0d", i));
        end
        exp_cnt = 1;
        check("vec_passed", n_pass, 12);
        chk_sts("frame1", 1'b0, 1'b0, 1'b0, 1'b0, exp_cnt);

        send_line(4, 1'b1, 1'b1, "f2");
        check("f2_busy_mid", {31'd0, sts_busy}, 32'd1);
        send_line(4, 1'b0, 1'b1, "f2");
        send_line(4, 1'b0, 1'b1, "f2");
        exp_cnt = 2;
        check("two_frames_passed", n_pass, 24);
        chk_sts("frame2", 1'b0, 1'b0, 1'b0, 1'b0, exp_cnt);

        // Short line 1, with err_clear coinciding with the setting beat
        send_line(4, 1'b1, 1'b1, "sh");
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "sh");
        err_clear = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "sh");
        err_clear = 1'b0;
        check("short_set_wins", {31'd0, sts_err_short}, 32'd1);
        send_line(4, 1'b0, 1'b1, "sh");
        chk_sts("short", 1'b0, 1'b1, 1'b0, 1'b0, exp_cnt);
        send_line(4, 1'b1, 1'b1, "ok3");
        send_line(4, 1'b0, 1'b1, "ok3");
        send_line(4, 1'b0, 1'b1, "ok3");
        exp_cnt = 3;
        chk_sts("after_short", 1'b0, 1'b1, 1'b0, 1'b0, exp_cnt);
        pulse_clear();
        chk_sts("clear1", 1'b0, 1'b0, 1'b0, 1'b0, exp_cnt);

        // Missing tlast on the 4th beat wraps the beat counter
        send_line(4, 1'b1, 1'b0, "lg");
        check("long_set", {31'd0, sts_err_long}, 32'd1);
        send_line(4, 1'b0, 1'b1, "lg");
        send_line(4, 1'b0, 1'b1, "lg");
        send_line(4, 1'b0, 1'b1, "lg");
        chk_sts("long", 1'b0, 1'b0, 1'b1, 1'b0, exp_cnt);
        pulse_clear();

        // SOF at line 1 beat 2 restarts a full frame that counts
        send_line(4, 1'b1, 1'b1, "es");
        send_line(2, 1'b0, 1'b0, "es");
        send_line(4, 1'b1, 1'b1, "es");
        check("early_set", {31'd0, sts_err_early_sof}, 32'd1);
        check("early_busy", {31'd0, sts_busy}, 32'd1);
        send_line(4, 1'b0, 1'b1, "es");
        send_line(4, 1'b0, 1'b1, "es");
        exp_cnt = 4;
        chk_sts("early", 1'b0, 1'b0, 1'b0, 1'b1, exp_cnt);
        pulse_clear();

        // Enable dropped mid-frame: frame still completes, then IDLE drops traffic
        got = n_pass;
        send_line(4, 1'b1, 1'b1, "dis");
        cfg_enable = 1'b0;
        send_line(4, 1'b0, 1'b1, "dis");
        send_line(4, 1'b0, 1'b1, "dis");
        exp_cnt = 5;
        check("dis_passed", n_pass - got, 12);
        chk_sts("dis", 1'b0, 1'b0, 1'b0, 1'b0, exp_cnt);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "dis_idle");
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "dis_idle");
        check("dis_dropped", n_pass - got, 12);
        cfg_enable = 1'b1;

        // Reset mid-frame
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "rst_pre");
        send_line(4, 1'b1, 1'b0, "rst_pre");
        @(negedge csi_clk);
        rsi_reset = 1'b1;
        @(posedge csi_clk);
        #1;
        rsi_reset = 1'b0;
        exp_cnt = 0;
        chk_sts("midreset", 1'b0, 1'b0, 1'b0, 1'b0, exp_cnt);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "rst_post");
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "rst_post");

        // Random downstream backpressure over a full frame
        got = 0;
        cyc = 0;
        while (got < 12 && cyc < 500) begin
            mr = 1'($urandom_range(0, 1));
            drive(1'b1, (got % 4) == 3, got == 0, mr, mr, 1'b1, "rnd");
            if (mr) got++;
            cyc++;
        end
        check("rnd_timeout", got, 12);
        exp_cnt = 1;
        chk_sts("rnd", 1'b0, 1'b0, 1'b0, 1'b0, exp_cnt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
